// File: rtl/ss_pkg.sv
// -----------------------------------------------------------------------------
// ss_pkg
// Shared types and constants for the signal-conditioning (debounce/sync) slice.
//   deb_state_e  : debounce FSM state encoding (2 bits)
//   SS_SYNC_MIN  : smallest usable synchroniser depth
//   f_level      : debounced level presented while in a given state
//   f_busy       : whether a given state is qualifying a candidate transition
// -----------------------------------------------------------------------------
package ss_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } deb_state_e;

    localparam int SS_SYNC_MIN = 2;

    // The accepted level stays put while a candidate is being qualified.
    function automatic logic f_level(input deb_state_e st);
        logic v;
        case (st)
            S_HIGH:  v = 1'b1;
            S_FALL:  v = 1'b1;
            S_LOW:   v = 1'b0;
            S_RISE:  v = 1'b0;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic f_busy(input deb_state_e st);
        logic v;
        case (st)
            S_RISE:  v = 1'b1;
            S_FALL:  v = 1'b1;
            S_LOW:   v = 1'b0;
            S_HIGH:  v = 1'b0;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ss_sync_chain.sv
// -----------------------------------------------------------------------------
// ss_sync_chain
// Multi-flop synchroniser bringing an asynchronous level into the i_clk domain.
// Ports:
//   i_clk : destination clock, rising edge
//   i_rst : synchronous active-high reset, loads every flop with RST_VAL
//   i_d   : asynchronous input level
//   o_q   : synchronised level (last flop of the chain)
// -----------------------------------------------------------------------------
module ss_sync_chain
    import ss_pkg::*;
#(
    parameter int   STAGES  = SS_SYNC_MIN,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift chain: bit 0 is the only flop that samples the asynchronous input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ss_debounce_sync.sv
// -----------------------------------------------------------------------------
// ss_debounce_sync
// Synchronises a raw asynchronous input and rejects pulses shorter than a
// stability window, presenting a clean level to the downstream edge detector.
// A new level is accepted once the synchronised input has held it for
// DEB_CYCLES+1 consecutive samples; anything shorter is dropped with a
// one-cycle o_glitch pulse.
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_signal : raw asynchronous input
//   o_signal : debounced, synchronised level (registered)
//   o_busy   : high while a candidate transition is being qualified
//   o_glitch : one-cycle pulse when a candidate transition is rejected
// -----------------------------------------------------------------------------
module ss_debounce_sync
    import ss_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_signal,
    output logic o_signal,
    output logic o_busy,
    output logic o_glitch
);

    localparam int            CW         = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CYCLES - 1);
    localparam deb_state_e    RST_STATE  = RST_VAL ? S_HIGH : S_LOW;

    logic            w_sync;
    deb_state_e      r_state;
    deb_state_e      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_glitch_nxt;
    logic            r_signal;
    logic            r_busy;
    logic            r_glitch;

    ss_sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_signal),
        .o_q   (w_sync)
    );

    // Next-state logic: a revert always wins over acceptance on the last count.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_glitch_nxt = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_sync) begin
                    w_state_nxt = S_RISE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = S_LOW;
                end
            end
            S_RISE: begin
                if (!w_sync) begin
                    w_state_nxt  = S_LOW;
                    w_cnt_nxt    = {CW{1'b0}};
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = S_FALL;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_FALL: begin
                if (w_sync) begin
                    w_state_nxt  = S_HIGH;
                    w_cnt_nxt    = {CW{1'b0}};
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and outputs; outputs decode the next state so they line
    // up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= RST_STATE;
            r_cnt    <= {CW{1'b0}};
            r_signal <= RST_VAL;
            r_busy   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_signal <= f_level(w_state_nxt);
            r_busy   <= f_busy(w_state_nxt);
            r_glitch <= w_glitch_nxt;
        end
    end

    assign o_signal = r_signal;
    assign o_busy   = r_busy;
    assign o_glitch = r_glitch;

endmodule

// File: tb/tb_ss_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_ss_debounce_sync
// Drives two instances (defaults, and SYNC_STAGES=3/DEB_CYCLES=1) with the same
// stimulus and compares every cycle against a run-length reference model.
// -----------------------------------------------------------------------------
module tb_ss_debounce_sync;

    logic clk;
    logic i_rst;
    logic i_signal;
    logic o_sig0, o_busy0, o_gl0;
    logic o_sig1, o_busy1, o_gl1;

    int checks = 0;
    int errors = 0;

    ss_debounce_sync u_dut0 (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_signal (i_signal),
        .o_signal (o_sig0),
        .o_busy   (o_busy0),
        .o_glitch (o_gl0)
    );

    ss_debounce_sync #(
        .SYNC_STAGES (3),
        .DEB_CYCLES  (1),
        .RST_VAL     (1'b0)
    ) u_dut1 (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_signal (i_signal),
        .o_signal (o_sig1),
        .o_busy   (o_busy1),
        .o_glitch (o_gl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a delay line for the synchroniser, then a count of how
    // many consecutive samples disagree with the accepted level.
    int         m_ss  [2] = '{2, 3};
    int         m_db  [2] = '{4, 1};
    logic [7:0] m_dl  [2];
    logic       m_lvl [2];
    int         m_run [2];
    logic       m_gl  [2];

    // Directed-test bookkeeping (instance 0 / 1).
    int e;
    int gl0, gl1, hi0, hi1;
    int rise0, rise1, fall0;
    logic prev0, prev1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        e = 0; gl0 = 0; gl1 = 0; hi0 = 0; hi1 = 0;
        rise0 = -1; rise1 = -1; fall0 = -1;
        prev0 = o_sig0; prev1 = o_sig1;
    endtask

    task automatic model_edge(input logic sig, input logic rst);
        logic s;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_dl[k]  = 8'h00;
                m_lvl[k] = 1'b0;
                m_run[k] = 0;
                m_gl[k]  = 1'b0;
            end else begin
                s        = m_dl[k][m_ss[k]-1];
                m_dl[k]  = {m_dl[k][6:0], sig};
                m_gl[k]  = 1'b0;
                if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == m_db[k] + 1) begin
                        m_lvl[k] = s;
                        m_run[k] = 0;
                    end
                end else begin
                    if (m_run[k] > 0) m_gl[k] = 1'b1;
                    m_run[k] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic sig, input logic rst);
        i_signal = sig;
        i_rst    = rst;
        @(posedge clk);
        model_edge(sig, rst);
        @(negedge clk);
        chk("d0_signal", int'(o_sig0),  int'(m_lvl[0]));
        chk("d0_busy",   int'(o_busy0), int'(m_run[0] > 0));
        chk("d0_glitch", int'(o_gl0),   int'(m_gl[0]));
        chk("d1_signal", int'(o_sig1),  int'(m_lvl[1]));
        chk("d1_busy",   int'(o_busy1), int'(m_run[1] > 0));
        chk("d1_glitch", int'(o_gl1),   int'(m_gl[1]));
        e++;
        if (o_gl0) gl0++;
        if (o_gl1) gl1++;
        if (o_sig0) hi0++;
        if (o_sig1) hi1++;
        if (o_sig0 && !prev0 && rise0 < 0) rise0 = e;
        if (!o_sig0 && prev0 && fall0 < 0) fall0 = e;
        if (o_sig1 && !prev1 && rise1 < 0) rise1 = e;
        prev0 = o_sig0;
        prev1 = o_sig1;
    endtask

    initial begin
        i_rst    = 1'b1;
        i_signal = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_dl[k] = 8'h00; m_lvl[k] = 1'b0; m_run[k] = 0; m_gl[k] = 1'b0;
        end

        // 1: reset with input held high, then full-latency acceptance.
        repeat (3) step(1'b1, 1'b1);
        chk("rst_signal", int'(o_sig0), 0);
        chk("rst_busy",   int'(o_busy0), 0);
        clr();
        repeat (10) step(1'b1, 1'b0);
        chk("lat_d0", rise0, 7);
        chk("lat_d1", rise1, 5);

        // 2: 3-cycle pulse is rejected once.
        repeat (2) step(1'b0, 1'b1);
        clr();
        repeat (3)  step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        chk("pulse_glitch", gl0, 1);
        chk("pulse_high",   hi0, 0);
        chk("pulse_busy",   int'(o_busy0), 0);

        // 3: exactly 5 cycles high is accepted, then the fall is qualified.
        repeat (2) step(1'b0, 1'b1);
        clr();
        repeat (5)  step(1'b1, 1'b0);
        repeat (14) step(1'b0, 1'b0);
        chk("min_rise", rise0, 7);
        chk("min_fall", fall0, 12);
        chk("min_glitch", gl0, 0);

        // 4: toggling every cycle never gets through.
        repeat (2) step(1'b0, 1'b1);
        clr();
        for (int i = 0; i < 20; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        chk("tog_glitch", gl0, 10);
        chk("tog_high",   hi0, 0);

        // 5: reset in the middle of qualification aborts silently.
        repeat (2) step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        chk("midq_busy_before", int'(o_busy0), 1);
        step(1'b1, 1'b1);
        chk("midq_busy",   int'(o_busy0), 0);
        chk("midq_signal", int'(o_sig0),  0);
        chk("midq_glitch", int'(o_gl0),   0);
        clr();
        repeat (10) step(1'b1, 1'b0);
        chk("midq_relat", rise0, 7);

        // 6: short configuration - 2 samples accepted, 1 sample rejected.
        repeat (2) step(1'b0, 1'b1);
        clr();
        repeat (2) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        chk("short_lat", rise1, 5);
        repeat (2) step(1'b0, 1'b1);
        clr();
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        chk("short_glitch", gl1, 1);
        chk("short_high",   hi1, 0);

        // Random runs of varying length with occasional resets.
        repeat (2) step(1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            logic lv;
            int   len;
            lv  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            if ($urandom_range(0, 29) == 0) begin
                step(lv, 1'b1);
            end else begin
                repeat (len) step(lv, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
